// File: rtl/sram_controller.sv
// Stalls the pipeline while it performs one 32-bit load or store as two 16-bit SRAM accesses.
// Strobes and read data are registered and follow the FSM state; ready is combinational.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic        dq_oe_q, dq_oe_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;

  logic [31:0] offset;
  logic        unused_offset;

  // Byte offset from the SRAM window; wraps below MEM_BASE, byte lanes dropped.
  assign offset        = address - MEM_BASE;
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          op_wr_d = 1'b1;
          idx_d   = offset[18:2];
          data_d  = write_data;
          state_d = StLo;
        end else if (rd_en) begin
          op_wr_d = 1'b0;
          idx_d   = offset[18:2];
          state_d = StLo;
        end
      end
      StLo: begin
        if (!op_wr_q) data_d[15:0] = sram_dq_in;
        state_d = StHi;
      end
      StHi: begin
        if (!op_wr_q) data_d[31:16] = sram_dq_in;
        cnt_d   = 4'd0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          if (!op_wr_q) rdata_d = data_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so they register in step with it.
    addr_d  = 18'd0;
    dq_d    = 16'd0;
    dq_oe_d = 1'b0;
    we_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    if (state_d == StLo || state_d == StHi) begin
      addr_d = {idx_d, state_d == StHi};
      if (op_wr_d) begin
        dq_d    = (state_d == StHi) ? data_d[31:16] : data_d[15:0];
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      idx_q   <= 17'd0;
      data_q  <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= 18'd0;
      dq_q    <= 16'd0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign ready       = (state_q == StDone) || (state_q == StIdle && !rd_en && !wr_en);
  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: table vectors, hand-written corner sequences and
// randomized accesses checked against a transaction-level model with an emulated SRAM.
module tb_sram_controller;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in = '0;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic        rd4 = 1'b0, wr4 = 1'b0;
  logic [31:0] addr4 = '0, wdata4 = '0;
  logic [31:0] rdata4;
  logic        ready4;
  logic [17:0] sram_addr4;
  logic [15:0] dq_out4, dq_in4;
  logic        dq_oe4, we_n4, oe_n4;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .MEM_BASE(BASE)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_controller #(.WAIT_CYCLES(4), .MEM_BASE(BASE)) u_dut4 (
    .clk(clk), .rst(rst), .rd_en(rd4), .wr_en(wr4), .address(addr4),
    .write_data(wdata4), .read_data(rdata4), .ready(ready4), .sram_addr(sram_addr4),
    .sram_dq_out(dq_out4), .sram_dq_in(dq_in4), .sram_dq_oe(dq_oe4),
    .sram_we_n(we_n4), .sram_oe_n(oe_n4)
  );

  assign dq_in4 = sram_addr4[15:0] ^ 16'h1111;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] sram_mem [logic [17:0]];
  logic [15:0] ref_mem  [logic [17:0]];
  logic [31:0] exp_rd_q = '0;

  function automatic logic [15:0] dflt(input logic [17:0] a);
    return a[15:0] * 16'h9E37 ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Emulated SRAM: stores on the write strobe, presents read data for the current address.
  always @(negedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] = sram_dq_out;
    sram_dq_in = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : dflt(sram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
  endtask

  task automatic chk_idle(input string tag, input logic exp_ready);
    chk({tag, " ready"}, 32'(ready), 32'(exp_ready));
    chk({tag, " addr"}, 32'(sram_addr), 32'd0);
    chk({tag, " we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, " oe_n"}, 32'(sram_oe_n), 32'd1);
    chk({tag, " dq_oe"}, 32'(sram_dq_oe), 32'd0);
    chk({tag, " dq_out"}, 32'(sram_dq_out), 32'd0);
    chk({tag, " rdata"}, read_data, exp_rd_q);
  endtask

  // One access from the request cycle (k=0) through DONE (k=3+W); entered and left #1 after
  // a rising edge. The next request (if any) is presented during DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [17:0] exp_lo,
                            input logic [31:0] exp_rdata, input logic nrd, input logic nwr,
                            input logic [31:0] na, input logic [31:0] nd);
    for (int k = 0; k <= 3 + W; k++) begin
      logic lo, hi, st;
      string t;
      if (k == 0) drive(rd, wr, a, d);
      else if (k < 3 + W) drive(1'($urandom), 1'($urandom), $urandom, $urandom);
      else drive(nrd, nwr, na, nd);
      @(negedge clk);
      lo = (k == 1);
      hi = (k == 2);
      st = lo || hi;
      t  = $sformatf("acc@%h k%0d", a, k);
      if (k == 3 + W) exp_rd_q = exp_rdata;
      chk({t, " ready"}, 32'(ready), 32'(k == 3 + W));
      chk({t, " addr"}, 32'(sram_addr), lo ? 32'(exp_lo) : hi ? 32'({exp_lo[17:1], 1'b1}) : 0);
      chk({t, " we_n"}, 32'(sram_we_n), 32'(!(wr && st)));
      chk({t, " oe_n"}, 32'(sram_oe_n), 32'(!(!wr && st)));
      chk({t, " dq_oe"}, 32'(sram_dq_oe), 32'(wr && st));
      chk({t, " dq_out"}, 32'(sram_dq_out),
          (wr && lo) ? 32'(d[15:0]) : (wr && hi) ? 32'(d[31:16]) : 32'd0);
      chk({t, " rdata"}, read_data, exp_rd_q);
      @(posedge clk); #1;
    end
    if (wr) begin
      ref_mem[exp_lo] = d[15:0];
      ref_mem[{exp_lo[17:1], 1'b1}] = d[31:16];
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_lo;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  vec_t vecs[9];
  txn_t txq[$];

  initial begin
    vecs[0] = '{0, 1, 32'd1024, 32'hDEADBEEF, 18'h00000, 32'h00000000};
    vecs[1] = '{1, 0, 32'd1028, 32'h0,        18'h00002, 32'h12345678};
    vecs[2] = '{1, 1, 32'd1032, 32'hCAFEF00D, 18'h00004, 32'h12345678};
    vecs[3] = '{1, 0, 32'd1024, 32'h0,        18'h00000, 32'hDEADBEEF};
    vecs[4] = '{1, 0, 32'd1032, 32'h0,        18'h00004, 32'hCAFEF00D};
    vecs[5] = '{0, 1, 32'd1023, 32'h0BADC0DE, 18'h3FFFE, 32'hCAFEF00D};
    vecs[6] = '{1, 0, 32'd1023, 32'h0,        18'h3FFFE, 32'h0BADC0DE};
    vecs[7] = '{0, 1, 32'd1026, 32'h11112222, 18'h00000, 32'h0BADC0DE};
    vecs[8] = '{1, 0, 32'd1024, 32'h0,        18'h00000, 32'h11112222};

    sram_mem[18'd2] = 16'h5678; sram_mem[18'd3] = 16'h1234;
    ref_mem[18'd2]  = 16'h5678; ref_mem[18'd3]  = 16'h1234;

    // Reset: outputs at their quiescent values, ready high while held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset", 1'b1);
    chk("reset ready4", 32'(ready4), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i])
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_lo,
                 vecs[i].exp_rdata, 0, 0, 0, 0);

    // Back-to-back reads: second request already present during the first DONE.
    run_access(1, 0, 32'd1024, 0, 18'd0, 32'h11112222, 1, 0, 32'd1028, 0);
    run_access(1, 0, 32'd1028, 0, 18'd2, 32'h12345678, 0, 0, 0, 0);
    @(negedge clk);
    chk_idle("after b2b", 1'b1);
    @(posedge clk); #1;

    // Reset asserted while a write sits in WAIT.
    drive(0, 1, 32'd1040, 32'hA5A5F0F0);
    repeat (3) begin @(posedge clk); #1; drive(0, 0, 0, 0); end
    chk("pre-reset ready", 32'(ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[18'd8] = 16'hF0F0;
    ref_mem[18'd9] = 16'hA5A5;
    exp_rd_q = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle($sformatf("post-reset c%0d", c), 1'b1);
      @(posedge clk); #1;
    end

    // Randomized accesses over a small window so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      txn_t t;
      int   kind;
      kind    = $urandom_range(0, 2);
      t.rd    = (kind != 1);
      t.wr    = (kind != 0);
      t.addr  = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) t.addr = BASE - 32'($urandom_range(1, 8));
      t.wdata = $urandom;
      txq.push_back(t);
    end
    for (int i = 0; i < txq.size(); i++) begin
      logic [31:0] off;
      logic [17:0] lo;
      logic [31:0] er;
      logic        b2b;
      txn_t        nx;
      off = txq[i].addr - BASE;
      lo  = {17'(off / 4), 1'b0};
      er  = txq[i].wr ? exp_rd_q : {ref_rd({lo[17:1], 1'b1}), ref_rd(lo)};
      b2b = (i + 1 < txq.size()) && $urandom_range(0, 1) == 1;
      nx  = b2b ? txq[i + 1] : '{0, 0, 0, 0};
      run_access(txq[i].rd, txq[i].wr, txq[i].addr, txq[i].wdata, lo, er,
                 nx.rd, nx.wr, nx.addr, nx.wdata);
      if (!b2b) begin
        @(negedge clk);
        chk_idle($sformatf("rand gap %0d", i), 1'b1);
        @(posedge clk); #1;
      end
    end

    // WAIT_CYCLES=4 instance: 7-cycle freeze and wrapped address below MEM_BASE.
    rd4 = 1'b1; addr4 = 32'd1023;
    for (int k = 0; k <= 7; k++) begin
      if (k == 1) begin rd4 = 1'b0; addr4 = 32'd0; end
      @(negedge clk);
      chk($sformatf("w4 k%0d ready", k), 32'(ready4), 32'(k == 7));
      chk($sformatf("w4 k%0d addr", k), 32'(sram_addr4),
          k == 1 ? 32'h3FFFE : k == 2 ? 32'h3FFFF : 32'd0);
      chk($sformatf("w4 k%0d oe_n", k), 32'(oe_n4), 32'(!(k == 1 || k == 2)));
      chk($sformatf("w4 k%0d we_n", k), 32'(we_n4), 32'd1);
      if (k == 7) chk("w4 rdata", rdata4, 32'hEEEEEEEF);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("w4 idle ready", 32'(ready4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of idle cycles after the second SRAM half-access; legal range 1..15.
REQ-002 Parameter MEM_BASE, default 32'd1024, SHALL set the byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rd_en  input  1  MEM-stage load request; level-sensitive.
REQ-006 wr_en  input  1  MEM-stage store request; level-sensitive.
REQ-007 address  input  32  byte address of the access (ALU result).
REQ-008 write_data  input  32  store data (Val_Rm).
REQ-009 read_data  output  32  load result, registered.
REQ-010 ready  output  1  high when the pipeline may advance; ~ready drives the global freeze.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  SRAM write data.
REQ-013 sram_dq_in  input  16  SRAM read data.
REQ-014 sram_dq_oe  output  1  high when the controller drives the DQ bus.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-016 sram_oe_n  output  1  SRAM output enable, active-low.

Function
REQ-017 FSM states SHALL be IDLE, LO, HI, WAIT, DONE; the op latch SHALL record read or write.
REQ-018 IDLE: if wr_en=1 the FSM SHALL latch op=write, address and write_data, then go to LO; otherwise, if rd_en=1, it SHALL latch op=read and address, then go to LO; otherwise it SHALL stay in IDLE.
REQ-019 When rd_en and wr_en are both 1, the write SHALL win and the read SHALL be ignored.
REQ-020 The word index SHALL be w = (address - MEM_BASE) mod 2^32, taking bits [18:2]; bits [1:0] SHALL be ignored.
REQ-021 In LO, sram_addr SHALL be {w[16:0],1'b0}; in HI, sram_addr SHALL be {w[16:0],1'b1}; in all other states, sram_addr SHALL be 0.
REQ-022 A write SHALL hold sram_we_n=0 and sram_dq_oe=1 in LO and HI, with sram_dq_out = data[15:0] in LO and data[31:16] in HI.
REQ-023 A read SHALL hold sram_oe_n=0 in LO and HI, capture sram_dq_in into the low half at the end of LO and into the high half at the end of HI.
REQ-024 Outside LO and HI: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-025 LO SHALL go to HI, and HI SHALL go to WAIT; WAIT SHALL count WAIT_CYCLES cycles, then go to DONE; DONE SHALL go to IDLE unconditionally.
REQ-026 ready SHALL be 1 in DONE, 1 in IDLE when rd_en=0 and wr_en=0, and 0 otherwise (combinational from state and requests).
REQ-027 Request first seen at cycle T: ready SHALL be low during cycles T..T+2+WAIT_CYCLES and high at T+3+WAIT_CYCLES; with the default, freeze SHALL last 5 cycles.
REQ-028 read_data SHALL become valid in DONE and SHALL hold its value until the next read reaches DONE; writes SHALL NOT change it.
REQ-029 Request inputs and write_data SHALL be ignored from LO through DONE; the latched values SHALL be used.
REQ-030 A request still asserted in the IDLE cycle after DONE SHALL start a new access (back-to-back, no idle gap).

Reset
REQ-031 rst=1 SHALL force: state IDLE, WAIT counter 0, read_data 0, latches 0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-032 rst asserted mid-access SHALL abort the access at the next edge; no further SRAM strobes SHALL occur, and read_data SHALL be 0.
REQ-033 ready during rst SHALL follow REQ-026 with state IDLE.

Verification
REQ-034 Write address=1024, data=32'hDEADBEEF -> LO: sram_addr=0, dq_out=16'hBEEF, we_n=0; HI: sram_addr=1, dq_out=16'hDEAD; ready low for 5 cycles, then high for 1 cycle.
REQ-035 Read address=1028, SRAM model returns 16'h5678 at sram_addr 2 and 16'h1234 at sram_addr 3 -> read_data=32'h12345678 in DONE; oe_n=0 only in LO and HI.
REQ-036 rd_en=1 and wr_en=1 at address 1032 -> write performed at sram_addr 4/5; read_data unchanged.
REQ-037 Two back-to-back reads (1024, then 1028) -> the second access's LO occurs 2 cycles after the first DONE; no spurious strobes in between.
REQ-038 rst pulsed during the WAIT state of a write -> next cycle: IDLE, we_n=1, dq_oe=0, read_data=0; ready=1 if no request.
REQ-039 WAIT_CYCLES=4 -> ready low for 7 cycles per access; address=1023 -> w=2^30-1 per REQ-020, with bits [18:2] giving sram_addr 18'h3FFFE/18'h3FFFF.
